// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   npc_sel_e             next-PC source chosen by the priority mux
//   DEFAULT_PC_STEP       sequential increment / call return offset
//   DEFAULT_RESET_VECTOR  PC value loaded on reset
package pc_pkg;

    typedef enum logic [1:0] {
        NPC_HOLD = 2'd0,
        NPC_INC  = 2'd1,
        NPC_LOAD = 2'd2,
        NPC_RET  = 2'd3
    } npc_sel_e;

    localparam int unsigned DEFAULT_PC_STEP      = 2;
    localparam int unsigned DEFAULT_RESET_VECTOR = 0;

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (discards all entries)
//   i_push       write i_push_data as the new top; overwrites the oldest entry when full
//   i_pop        drop the top entry; no-op when empty
//   i_push_data  return address to store
//   o_top        current top entry (meaningful only when not empty)
//   o_count      number of valid entries, 0..RAS_DEPTH
//   o_full       o_count == RAS_DEPTH
//   o_empty      o_count == 0
// Push and pop are never requested together by the sequencer; push wins if they are.
module pc_ras #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_push_data,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(RAS_DEPTH):0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;

    // Depth is a power of two, so the pointer wraps for free.
    assign w_top_inc = r_top + PW'(1);
    assign w_top_dec = r_top - PW'(1);

    assign o_full  = (r_count == CW'(RAS_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_top   = r_mem[r_top];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_top <= w_top_inc;
            // When full the new entry lands on the oldest slot; count saturates.
            if (!o_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_top   <= w_top_dec;
            r_count <= r_count - CW'(1);
        end
    end

    // NOTE: entry storage has no reset; validity is tracked by r_count alone,
    // which keeps the array free of reset fan-out.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_top_inc] <= i_push_data;
        end
    end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// Program-counter unit with branch/jump selection and a return-address stack.
//   CLK           rising-edge clock
//   Reset         synchronous active-high; overrides every other input
//   Stall         freeze PC, RAS and sticky flags
//   Inc           sequential advance by PC_STEP
//   PCWrite       unconditional load of DataIn
//   PCWriteBeq    load DataIn when Is_Zero
//   PCWriteBne    load DataIn when !Is_Zero
//   Is_Zero       ALU zero flag
//   Call          push PC+PC_STEP when a load is taken
//   Ret           pop RAS top into PC
//   DataIn        jump/branch target
//   DataOut       registered PC
//   RASCount      valid RAS entries
//   RASOverflow   sticky: push while full
//   RASUnderflow  sticky: Ret while empty
//   CallRetErr    sticky: Call and Ret together
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned PC_STEP      = DEFAULT_PC_STEP,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         Stall,
    input  logic                         Inc,
    input  logic                         PCWrite,
    input  logic                         PCWriteBeq,
    input  logic                         PCWriteBne,
    input  logic                         Is_Zero,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic [WIDTH-1:0]             DataIn,
    output logic [WIDTH-1:0]             DataOut,
    output logic [$clog2(RAS_DEPTH):0]   RASCount,
    output logic                         RASOverflow,
    output logic                         RASUnderflow,
    output logic                         CallRetErr
);

    logic [WIDTH-1:0] r_pc;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_call_ret_err;

    logic             w_taken;
    npc_sel_e         w_sel;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_push;
    logic             w_pop;
    logic             w_set_overflow;
    logic             w_set_underflow;
    logic             w_set_call_ret_err;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_full;
    logic             w_ras_empty;

    assign w_taken  = PCWrite | (PCWriteBeq & Is_Zero) | (PCWriteBne & ~Is_Zero);
    // Modulo 2^WIDTH: the carry out is simply dropped.
    assign w_pc_inc = r_pc + WIDTH'(PC_STEP);

    // NOTE: every combinational output gets a default before any branch, so no
    // path through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_sel              = NPC_HOLD;
        w_push             = 1'b0;
        w_pop              = 1'b0;
        w_set_overflow     = 1'b0;
        w_set_underflow    = 1'b0;
        w_set_call_ret_err = 1'b0;
        if (!Stall) begin
            if (Ret) begin
                // Ret always wins; a simultaneous Call is dropped and flagged.
                w_set_call_ret_err = Call;
                if (!w_ras_empty) begin
                    w_sel = NPC_RET;
                    w_pop = 1'b1;
                end else begin
                    w_set_underflow = 1'b1;
                end
            end else if (w_taken) begin
                w_sel          = NPC_LOAD;
                w_push         = Call;
                w_set_overflow = Call & w_ras_full;
            end else if (Inc) begin
                w_sel = NPC_INC;
            end
        end

        unique case (w_sel)
            NPC_RET:  w_next_pc = w_ras_top;
            NPC_LOAD: w_next_pc = DataIn;
            NPC_INC:  w_next_pc = w_pc_inc;
            default:  w_next_pc = r_pc;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc           <= WIDTH'(RESET_VECTOR);
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_call_ret_err <= 1'b0;
        end else begin
            r_pc           <= w_next_pc;
            r_overflow     <= r_overflow     | w_set_overflow;
            r_underflow    <= r_underflow    | w_set_underflow;
            r_call_ret_err <= r_call_ret_err | w_set_call_ret_err;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (CLK),
        .i_rst       (Reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_count     (RASCount),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty)
    );

    assign DataOut      = r_pc;
    assign RASOverflow  = r_overflow;
    assign RASUnderflow = r_underflow;
    assign CallRetErr   = r_call_ret_err;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (WIDTH=16, PC_STEP=2, RAS_DEPTH=4).
// Stimulus pushes hand-computed expectations into a queue; the monitor pops
// one entry after each rising edge and compares it to the DUT outputs.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, inc, pcw, beq, bne, zero, call, ret;
    logic [15:0] din;
    logic [15:0] dout;
    logic [2:0]  cnt;
    logic        ovf, unf, cre;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
        logic        cre;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH        (16),
        .RESET_VECTOR (0),
        .PC_STEP      (2),
        .RAS_DEPTH    (4)
    ) dut (
        .CLK          (clk),
        .Reset        (rst),
        .Stall        (stall),
        .Inc          (inc),
        .PCWrite      (pcw),
        .PCWriteBeq   (beq),
        .PCWriteBne   (bne),
        .Is_Zero      (zero),
        .Call         (call),
        .Ret          (ret),
        .DataIn       (din),
        .DataOut      (dout),
        .RASCount     (cnt),
        .RASOverflow  (ovf),
        .RASUnderflow (unf),
        .CallRetErr   (cre)
    );

    // Monitor: one expectation per clock edge, sampled 1 ns after the edge.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (dout !== e.pc || cnt !== e.cnt || ovf !== e.ovf ||
                unf !== e.unf || cre !== e.cre) begin
                n_bad++;
                $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b cre=%b, want pc=%h cnt=%0d ovf=%b unf=%b cre=%b",
                         e.name, dout, cnt, ovf, unf, cre, e.pc, e.cnt, e.ovf, e.unf, e.cre);
            end
        end
    end

    task automatic drv(input bit s, input bit i, input bit w, input bit bq, input bit bn,
                       input bit z, input bit c, input bit r, input logic [15:0] d);
        stall = s; inc = i; pcw = w; beq = bq; bne = bn;
        zero = z;  call = c; ret = r; din = d;
    endtask

    // Queue the expectation for the coming edge, then move to the next falling edge.
    task automatic tick(input string nm, input logic [15:0] pc, input logic [2:0] c,
                        input logic o, input logic u, input logic e);
        exp_t x;
        x.name = nm; x.pc = pc; x.cnt = c; x.ovf = o; x.unf = u; x.cre = e;
        q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 1, 0, 0, 0, 0, 0, 16'h0055);
        @(negedge clk);
        tick("reset1", 16'h0000, 0, 0, 0, 0);
        tick("reset2", 16'h0000, 0, 0, 0, 0);
        rst = 1'b0;

        // Jump and conditional branches
        drv(0, 0, 1, 0, 0, 0, 0, 0, 16'h0001); tick("jump",        16'h0001, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0, 0, 16'h0003); tick("beq_nt",      16'h0001, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 1, 0, 0, 16'h0004); tick("beq_t",       16'h0004, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 1, 0, 0, 16'h0005); tick("bne_nt",      16'h0004, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 16'h0006); tick("bne_t",       16'h0006, 0, 0, 0, 0);
        drv(0, 1, 0, 1, 0, 1, 0, 0, 16'h0040); tick("load_over_inc", 16'h0040, 0, 0, 0, 0);
        drv(0, 1, 0, 1, 0, 0, 0, 0, 16'h0080); tick("inc_nt_branch", 16'h0042, 0, 0, 0, 0);

        // Single call/return
        drv(0, 0, 1, 0, 0, 0, 0, 0, 16'h0010); tick("pc_0x10",     16'h0010, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0100); tick("call1",       16'h0100, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000); tick("ret1",        16'h0012, 0, 0, 0, 0);

        // Five nested calls overflow a 4-deep stack
        drv(0, 0, 1, 0, 0, 0, 0, 0, 16'h0010); tick("pc_0x10b",    16'h0010, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0020); tick("callA",       16'h0020, 1, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0030); tick("callB",       16'h0030, 2, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0040); tick("callC",       16'h0040, 3, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0050); tick("callD",       16'h0050, 4, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0060); tick("callE_ovf",   16'h0060, 4, 1, 0, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 1, 16'h0999); tick("retA",        16'h0052, 3, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000); tick("retB",        16'h0042, 2, 1, 0, 0);
        tick("retC",                                                16'h0032, 1, 1, 0, 0);
        tick("retD",                                                16'h0022, 0, 1, 0, 0);
        tick("retE_unf",                                            16'h0022, 0, 1, 1, 0);

        // Wrap on increment
        drv(0, 0, 1, 0, 0, 0, 0, 0, 16'hFFFE); tick("pc_fffe",     16'hFFFE, 0, 1, 1, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 16'h0000); tick("inc_wrap",    16'h0000, 0, 1, 1, 0);

        // Stall freezes everything, including the Call&Ret error flag
        drv(0, 0, 1, 0, 0, 0, 1, 0, 16'h0200); tick("call_0x200",  16'h0200, 1, 1, 1, 0);
        drv(1, 1, 1, 0, 0, 0, 1, 1, 16'h0999);
        for (int i = 0; i < 3; i++) begin
            tick("stall", 16'h0200, 1, 1, 1, 0);
        end

        // Call & Ret together: pop wins, no push, error flagged
        drv(0, 0, 1, 0, 0, 0, 1, 1, 16'h0300); tick("call_ret",    16'h0002, 0, 1, 1, 1);
        // Call without a taken load is ignored
        drv(0, 1, 0, 0, 0, 0, 1, 0, 16'h0400); tick("call_no_load", 16'h0004, 0, 1, 1, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000); tick("idle_hold",   16'h0004, 0, 1, 1, 1);

        // Reset clears sticky flags and the stack
        rst = 1'b1;
        drv(0, 1, 1, 0, 0, 0, 1, 0, 16'h0123); tick("reset_end",   16'h0000, 0, 0, 0, 0);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000); tick("post_reset",  16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_sequencer
